// File: rtl/submit_schedule_mc.sv
// Time-slot submit scheduler: walks a slot table held in a dual-port RAM and issues
// per-entry submit requests to the TS submit manager when the entry's slot comes up.
module submit_schedule_mc #(
  parameter int unsigned DEPTH_W = 10,
  parameter int unsigned SLOT_W  = 10,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned CH_W    = 3,
  parameter int unsigned MISS_W  = 16,
  localparam int unsigned EW     = 1 + SLOT_W + CH_W + ADDR_W,
  localparam int unsigned NCH    = 2 ** CH_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         iv_cfg_finish,
  input  logic [SLOT_W-1:0]  iv_time_slot,
  input  logic               i_time_slot_switch,
  input  logic [NCH-1:0]     iv_ch_enable,
  input  logic [EW-1:0]      iv_submit_slot_table_wdata,
  input  logic               i_submit_slot_table_wr,
  input  logic [DEPTH_W-1:0] iv_submit_slot_table_addr,
  input  logic               i_submit_slot_table_rd,
  output logic [EW-1:0]      ov_submit_slot_table_rdata,
  output logic [ADDR_W-1:0]  ov_ts_submit_addr,
  output logic [CH_W-1:0]    ov_ts_submit_ch,
  output logic               o_ts_submit_addr_wr,
  input  logic               i_ts_submit_addr_ack,
  output logic [MISS_W-1:0]  ov_miss_cnt,
  output logic [2:0]         ov_ssm_state
);

  typedef enum logic [2:0] {
    StWaitCfg      = 3'd0,
    StIdle         = 3'd1,
    StWaitRd       = 3'd2,
    StGetData      = 3'd3,
    StWaitSched    = 3'd4,
    StWaitAck      = 3'd5,
    StWaitNextSlot = 3'd6
  } state_e;

  logic [EW-1:0] mem [2**DEPTH_W];

  state_e             state_q;
  logic [DEPTH_W-1:0] ptr_q;
  logic               wrap_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CH_W-1:0]    ch_q;
  logic [MISS_W-1:0]  miss_q;
  logic [EW-1:0]      rdata_a_q;
  logic [EW-1:0]      rdata_b_q;

  // Table RAM contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_submit_slot_table_wr) begin
      mem[iv_submit_slot_table_addr] <= iv_submit_slot_table_wdata;
    end
  end

  // Both read ports see pre-write contents on a same-cycle collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (i_submit_slot_table_rd) rdata_a_q <= mem[iv_submit_slot_table_addr];
      if (state_q == StIdle)      rdata_b_q <= mem[ptr_q];
    end
  end

  logic              ent_valid;
  logic [SLOT_W-1:0] ent_slot;
  logic [CH_W-1:0]   ent_ch;
  logic [ADDR_W-1:0] ent_addr;
  logic              ent_match;
  logic              ent_en;
  logic              ptr_last;

  always_comb begin
    ent_valid = rdata_b_q[EW-1];
    ent_slot  = rdata_b_q[EW-2 -: SLOT_W];
    ent_ch    = rdata_b_q[ADDR_W+CH_W-1 -: CH_W];
    ent_addr  = rdata_b_q[ADDR_W-1:0];
    ent_match = (ent_slot == iv_time_slot);
    ent_en    = iv_ch_enable[ent_ch];
    ptr_last  = &ptr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StWaitCfg;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      ch_q    <= '0;
      miss_q  <= '0;
    end else if (state_q != StWaitCfg && iv_cfg_finish != 2'd3) begin
      state_q <= StWaitCfg;
      ptr_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      ch_q    <= '0;
    end else begin
      unique case (state_q)
        StWaitCfg: if (iv_cfg_finish == 2'd3) state_q <= StIdle;
        StIdle:    state_q <= StWaitRd;
        StWaitRd:  state_q <= StGetData;
        StGetData, StWaitSched: begin
          if (!ent_valid) begin
            ptr_q   <= '0;
            state_q <= StWaitNextSlot;
          end else if (!ent_en && (state_q == StGetData || ent_match)) begin
            // Disabled channel: skip; in WAIT_SCHED this is decided at issue time.
            ptr_q   <= ptr_q + DEPTH_W'(1);
            state_q <= ptr_last ? StWaitNextSlot : StIdle;
          end else if (ent_match) begin
            wr_q    <= 1'b1;
            addr_q  <= ent_addr;
            ch_q    <= ent_ch;
            wrap_q  <= ptr_last;
            ptr_q   <= ptr_q + DEPTH_W'(1);
            state_q <= StWaitAck;
          end else begin
            state_q <= StWaitSched;
          end
        end
        StWaitAck: begin
          if (i_ts_submit_addr_ack) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            ch_q    <= '0;
            state_q <= wrap_q ? StWaitNextSlot : StIdle;
          end else if (i_time_slot_switch) begin
            wr_q    <= 1'b0;
            if (miss_q != '1) miss_q <= miss_q + MISS_W'(1);
            state_q <= StIdle;
          end
        end
        StWaitNextSlot: if (i_time_slot_switch) state_q <= StIdle;
        default: state_q <= StWaitCfg;
      endcase
    end
  end

  assign ov_submit_slot_table_rdata = rdata_a_q;
  assign ov_ts_submit_addr          = addr_q;
  assign ov_ts_submit_ch            = ch_q;
  assign o_ts_submit_addr_wr        = wr_q;
  assign ov_miss_cnt                = miss_q;
  assign ov_ssm_state               = state_q;

endmodule

// File: tb/tb_submit_schedule_mc.sv
// Directed bench for submit_schedule_mc with a 4-entry table (DEPTH_W=2).
module tb_submit_schedule_mc;

  localparam int unsigned EW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cfg_finish;
  logic [9:0]    time_slot;
  logic          slot_switch;
  logic [7:0]    ch_enable;
  logic [EW-1:0] tbl_wdata;
  logic          tbl_wr;
  logic [1:0]    tbl_addr;
  logic          tbl_rd;
  logic [EW-1:0] tbl_rdata;
  logic [4:0]    sub_addr;
  logic [2:0]    sub_ch;
  logic          sub_wr;
  logic          ack;
  logic [15:0]   miss_cnt;
  logic [2:0]    ssm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  localparam logic [2:0] SWaitCfg = 3'd0, SIdle = 3'd1, SWaitSched = 3'd4,
                         SWaitAck = 3'd5, SWaitNext = 3'd6;

  submit_schedule_mc #(.DEPTH_W(2)) dut (
    .i_clk                      (clk),
    .i_rst                      (rst),
    .iv_cfg_finish              (cfg_finish),
    .iv_time_slot               (time_slot),
    .i_time_slot_switch         (slot_switch),
    .iv_ch_enable               (ch_enable),
    .iv_submit_slot_table_wdata (tbl_wdata),
    .i_submit_slot_table_wr     (tbl_wr),
    .iv_submit_slot_table_addr  (tbl_addr),
    .i_submit_slot_table_rd     (tbl_rd),
    .ov_submit_slot_table_rdata (tbl_rdata),
    .ov_ts_submit_addr          (sub_addr),
    .ov_ts_submit_ch            (sub_ch),
    .o_ts_submit_addr_wr        (sub_wr),
    .i_ts_submit_addr_ack       (ack),
    .ov_miss_cnt                (miss_cnt),
    .ov_ssm_state               (ssm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] mk(input logic v, input int slot, input int ch, input int a);
    mk = {v, 10'(slot), 3'(ch), 5'(a)};
  endfunction

  task automatic wr_entry(input int a, input logic [EW-1:0] d);
    tbl_addr  = 2'(a);
    tbl_wdata = d;
    tbl_wr    = 1'b1;
    tick();
    tbl_wr    = 1'b0;
  endtask

  task automatic load4(input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                       input logic [EW-1:0] e2, input logic [EW-1:0] e3);
    wr_entry(0, e0);
    wr_entry(1, e1);
    wr_entry(2, e2);
    wr_entry(3, e3);
  endtask

  // Cycles until a request is raised; capped at 20 so a stuck DUT still ends the run.
  task automatic wait_wr(output int cycles);
    cycles = 0;
    while (!sub_wr && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_switch();
    slot_switch = 1'b1;
    tick();
    slot_switch = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_finish = 2'd0; time_slot = 10'd5; slot_switch = 1'b0;
    ch_enable = 8'hFF; tbl_wdata = '0; tbl_wr = 1'b0; tbl_addr = '0; tbl_rd = 1'b0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 32'(ssm_state), 32'(SWaitCfg));
    check("rst_wr", 32'(sub_wr), 0);
    check("rst_miss", 32'(miss_cnt), 0);
    check("rst_rdata", 32'(tbl_rdata), 0);

    // Cfg port read/write, including read-during-write returning old contents.
    wr_entry(3, 19'h01234);
    tbl_addr = 2'd3; tbl_rd = 1'b1;
    tick();
    tbl_rd = 1'b0;
    check("cfg_rd", 32'(tbl_rdata), 32'h1234);
    tbl_addr = 2'd3; tbl_rd = 1'b1; tbl_wr = 1'b1; tbl_wdata = 19'h00055;
    tick();
    tbl_rd = 1'b0; tbl_wr = 1'b0;
    check("cfg_rd_wr_old", 32'(tbl_rdata), 32'h1234);
    tbl_rd = 1'b1;
    tick();
    tbl_rd = 1'b0;
    check("cfg_rd_new", 32'(tbl_rdata), 32'h55);

    // Two same-slot entries then an invalid one.
    load4(mk(1, 5, 2, 7), mk(1, 5, 1, 3), mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    cfg_finish = 2'd3;
    wait_wr(n);
    check("t2_first_lat", 32'(n), 4);
    check("t2_addr0", 32'(sub_addr), 7);
    check("t2_ch0", 32'(sub_ch), 2);
    check("t2_state_ack", 32'(ssm_state), 32'(SWaitAck));
    pulse_ack();
    check("t2_wr_drop", 32'(sub_wr), 0);
    check("t2_addr_clr", 32'(sub_addr), 0);
    wait_wr(n);
    check("t2_spacing", 32'(n), 3);
    check("t2_addr1", 32'(sub_addr), 3);
    check("t2_ch1", 32'(sub_ch), 1);
    pulse_ack();
    tick(); tick(); tick();
    check("t2_next_slot", 32'(ssm_state), 32'(SWaitNext));
    tick(); tick(); tick();
    check("t2_hold_state", 32'(ssm_state), 32'(SWaitNext));
    check("t2_hold_wr", 32'(sub_wr), 0);
    pulse_switch();
    check("t2_switch_idle", 32'(ssm_state), 32'(SIdle));
    wait_wr(n);
    check("t2_reread_lat", 32'(n), 3);
    check("t2_reread_addr", 32'(sub_addr), 7);
    cfg_finish = 2'd1;
    tick();
    check("t6_cfgloss_state", 32'(ssm_state), 32'(SWaitCfg));
    check("t6_cfgloss_wr", 32'(sub_wr), 0);
    check("t6_cfgloss_addr", 32'(sub_addr), 0);
    check("t6_cfgloss_miss", 32'(miss_cnt), 0);

    // Future slot waits, then miss on un-acked switch, then ack+switch counts as acked.
    load4(mk(1, 9, 0, 4), mk(0, 0, 0, 0), mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    time_slot = 10'd8;
    cfg_finish = 2'd3;
    repeat (6) tick();
    check("t3_wait_wr", 32'(sub_wr), 0);
    check("t3_wait_state", 32'(ssm_state), 32'(SWaitSched));
    time_slot = 10'd9;
    tick();
    check("t3_issue_wr", 32'(sub_wr), 1);
    check("t3_issue_addr", 32'(sub_addr), 4);
    check("t3_issue_ch", 32'(sub_ch), 0);
    pulse_switch();
    check("t5_miss_wr", 32'(sub_wr), 0);
    check("t5_miss_cnt", 32'(miss_cnt), 1);
    check("t5_miss_state", 32'(ssm_state), 32'(SIdle));
    tick(); tick(); tick();
    check("t5_invalid_next", 32'(ssm_state), 32'(SWaitNext));
    pulse_switch();
    wait_wr(n);
    check("t5_reissue_addr", 32'(sub_addr), 4);
    ack = 1'b1; slot_switch = 1'b1;
    tick();
    ack = 1'b0; slot_switch = 1'b0;
    check("t5_ackswitch_wr", 32'(sub_wr), 0);
    check("t5_ackswitch_miss", 32'(miss_cnt), 1);
    check("t5_ackswitch_state", 32'(ssm_state), 32'(SIdle));
    cfg_finish = 2'd0;
    tick();
    check("t5_cfgloss_miss", 32'(miss_cnt), 1);

    // Disabled channel 2 is skipped.
    ch_enable = 8'hFB;
    time_slot = 10'd5;
    load4(mk(1, 5, 2, 7), mk(1, 5, 0, 6), mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    cfg_finish = 2'd3;
    wait_wr(n);
    check("t4_skip_lat", 32'(n), 7);
    check("t4_addr", 32'(sub_addr), 6);
    check("t4_ch", 32'(sub_ch), 0);
    pulse_ack();
    cfg_finish = 2'd0;
    tick();
    ch_enable = 8'hFF;

    // Full table: pointer wraps after the last entry.
    load4(mk(1, 5, 0, 10), mk(1, 5, 1, 11), mk(1, 5, 2, 12), mk(1, 5, 3, 13));
    cfg_finish = 2'd3;
    for (int c = 0; c < 4; c++) begin
      wait_wr(n);
      check($sformatf("wrap_addr%0d", c), 32'(sub_addr), 32'(10 + c));
      pulse_ack();
    end
    check("wrap_next_slot", 32'(ssm_state), 32'(SWaitNext));
    pulse_switch();
    wait_wr(n);
    check("wrap_ptr0_addr", 32'(sub_addr), 10);

    // Reset held two cycles in WAIT_ACK.
    rst = 1'b1;
    tick();
    check("t1_rst_wr", 32'(sub_wr), 0);
    check("t1_rst_miss", 32'(miss_cnt), 0);
    check("t1_rst_state", 32'(ssm_state), 32'(SWaitCfg));
    tick();
    rst = 1'b0;
    check("t1_rst_hold_state", 32'(ssm_state), 32'(SWaitCfg));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
